// File: rtl/spart_if.sv
// spart_if: SPART bus control lines and receive/transmit status handshake
interface spart_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;
    modport master(output iocs, iorw, ioaddr, input rda, tbr);
    modport slave(input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor, then echoes every received byte
module spart_driver #(
    parameter logic [15:0] DIV_4800  = 16'h028C,
    parameter logic [15:0] DIV_9600  = 16'h0145,
    parameter logic [15:0] DIV_19200 = 16'h00A3,
    parameter logic [15:0] DIV_38400 = 16'h0052
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    spart_if.master    bus,
    inout  wire  [7:0] databus,
    output logic [7:0] last_byte,
    output logic [7:0] echo_cnt
);
    typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD_RX, WAIT_TBR, WR_TX} state_t;
    state_t     state, next_state;
    logic [1:0] cfg_m, cfg_s, cfg;
    logic [7:0] dout;
    logic [15:0] div_new, div_cur;

    assign databus = (bus.iocs && !bus.iorw) ? dout : 8'bz;

    // two-flop synchroniser, left free-running so it has settled by the time reset releases
    always_ff @(posedge clk) begin
        cfg_m <= br_cfg;
        cfg_s <= cfg_m;
    end

    // divisor for the freshly synchronised selection and for the latched one
    always_comb begin
        div_new = cfg_s == 2'b00 ? DIV_4800 : cfg_s == 2'b01 ? DIV_9600 : cfg_s == 2'b10 ? DIV_19200 : DIV_38400;
        div_cur = cfg == 2'b00 ? DIV_4800 : cfg == 2'b01 ? DIV_9600 : cfg == 2'b10 ? DIV_19200 : DIV_38400;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CFG_LO;
        else     state <= next_state;
    end

    // next state; out of reset CFG_LO holds one cycle while its access is issued
    always_comb begin
        next_state = state;
        case (state)
            CFG_LO:   next_state = bus.iocs ? CFG_HI : CFG_LO;
            CFG_HI:   next_state = IDLE;
            IDLE:     next_state = cfg_s != cfg ? CFG_LO : bus.rda ? RD_RX : IDLE;
            RD_RX:    next_state = WAIT_TBR;
            WAIT_TBR: next_state = bus.tbr ? WR_TX : WAIT_TBR;
            WR_TX:    next_state = IDLE;
            default:  next_state = CFG_LO;
        endcase
    end

    // bus outputs registered from the state being entered; capture and count at the end of an access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.iocs   <= 1'b0;
            bus.iorw   <= 1'b1;
            bus.ioaddr <= 2'b00;
            dout       <= 8'h00;
            cfg        <= 2'b00;
            last_byte  <= 8'h00;
            echo_cnt   <= 8'h00;
        end else begin
            bus.iocs   <= next_state != IDLE && next_state != WAIT_TBR;
            bus.iorw   <= next_state == RD_RX || next_state == IDLE || next_state == WAIT_TBR;
            bus.ioaddr <= next_state == CFG_LO ? 2'b10 : next_state == CFG_HI ? 2'b11 : 2'b00;
            dout       <= next_state == CFG_LO ? div_new[7:0] : next_state == CFG_HI ? div_cur[15:8] : last_byte;
            cfg        <= next_state == CFG_LO ? cfg_s : cfg;
            last_byte  <= state == RD_RX ? databus : last_byte;
            echo_cnt   <= echo_cnt + {7'd0, state == WR_TX};
        end
    end
endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: directed checks of divisor programming, echo loop, wrap and reset behaviour
module tb_spart_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b01;
    logic [7:0] rx_byte = 8'h00;
    wire  [7:0] databus;
    logic [7:0] last_byte, echo_cnt;
    logic [7:0] exp_cnt;
    int n_cmp = 0;
    int n_bad = 0;

    spart_if bus();

    spart_driver dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .bus(bus),
        .databus(databus), .last_byte(last_byte), .echo_cnt(echo_cnt)
    );

    always #5 clk = ~clk;

    // SPART model: drives the receive byte during a buffer read; pullups make a released bus read 8'hFF
    assign databus = (bus.iocs && bus.iorw && bus.ioaddr == 2'b00) ? rx_byte : 8'bz;
    for (genvar g = 0; g < 8; g++) begin : pu
        pullup (databus[g]);
    end

    task cyc();
        @(negedge clk);
    endtask

    task test_reset();
        bus.rda = 1'b0; bus.tbr = 1'b0; rst = 1'b1; br_cfg = 2'b01;
        repeat (3) cyc();
        n_cmp++; if (bus.iocs !== 1'b0) begin n_bad++; $display("FAIL rst_iocs got %h want 0", bus.iocs); end
        n_cmp++; if (bus.iorw !== 1'b1) begin n_bad++; $display("FAIL rst_iorw got %h want 1", bus.iorw); end
        n_cmp++; if (bus.ioaddr !== 2'b00) begin n_bad++; $display("FAIL rst_ioaddr got %h want 0", bus.ioaddr); end
        n_cmp++; if (databus !== 8'hFF) begin n_bad++; $display("FAIL rst_bus_released got %h want ff", databus); end
        n_cmp++; if (last_byte !== 8'h00) begin n_bad++; $display("FAIL rst_last_byte got %h want 00", last_byte); end
        n_cmp++; if (echo_cnt !== 8'h00) begin n_bad++; $display("FAIL rst_echo_cnt got %h want 00", echo_cnt); end
        rst = 1'b0;
        cyc();
        n_cmp++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1010) begin n_bad++; $display("FAIL cfg_lo_ctl got %b want 1010", {bus.iocs, bus.iorw, bus.ioaddr}); end
        n_cmp++; if (databus !== 8'h45) begin n_bad++; $display("FAIL cfg_lo_data got %h want 45", databus); end
        cyc();
        n_cmp++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1011) begin n_bad++; $display("FAIL cfg_hi_ctl got %b want 1011", {bus.iocs, bus.iorw, bus.ioaddr}); end
        n_cmp++; if (databus !== 8'h01) begin n_bad++; $display("FAIL cfg_hi_data got %h want 01", databus); end
        cyc();
        n_cmp++; if (bus.iocs !== 1'b0) begin n_bad++; $display("FAIL cfg_done_iocs got %h want 0", bus.iocs); end
        n_cmp++; if (databus !== 8'hFF) begin n_bad++; $display("FAIL cfg_done_bus got %h want ff", databus); end
    endtask

    task test_echo();
        rx_byte = 8'hA5; bus.rda = 1'b1; bus.tbr = 1'b1;
        cyc();
        n_cmp++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1100) begin n_bad++; $display("FAIL echo_rd_ctl got %b want 1100", {bus.iocs, bus.iorw, bus.ioaddr}); end
        bus.rda = 1'b0;
        cyc();
        n_cmp++; if (last_byte !== 8'hA5) begin n_bad++; $display("FAIL echo_last_byte got %h want a5", last_byte); end
        n_cmp++; if (bus.iocs !== 1'b0) begin n_bad++; $display("FAIL echo_gap_iocs got %h want 0", bus.iocs); end
        cyc();
        n_cmp++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1000) begin n_bad++; $display("FAIL echo_wr_ctl got %b want 1000", {bus.iocs, bus.iorw, bus.ioaddr}); end
        n_cmp++; if (databus !== 8'hA5) begin n_bad++; $display("FAIL echo_wr_data got %h want a5", databus); end
        cyc();
        n_cmp++; if (echo_cnt !== 8'h01) begin n_bad++; $display("FAIL echo_cnt got %h want 01", echo_cnt); end
        n_cmp++; if (bus.iocs !== 1'b0) begin n_bad++; $display("FAIL echo_idle_iocs got %h want 0", bus.iocs); end
    endtask

    task test_tbr_wait();
        bus.tbr = 1'b0; rx_byte = 8'h3C; bus.rda = 1'b1;
        cyc();
        n_cmp++; if ({bus.iocs, bus.iorw} !== 2'b11) begin n_bad++; $display("FAIL wait_rd_ctl got %b want 11", {bus.iocs, bus.iorw}); end
        bus.rda = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_cmp++; if (bus.iocs !== 1'b0) begin n_bad++; $display("FAIL wait_hold_%0d got iocs %h want 0", i, bus.iocs); end
            if (i == 10) begin bus.rda = 1'b1; rx_byte = 8'hC3; end
        end
        bus.tbr = 1'b1;
        cyc();
        n_cmp++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1000) begin n_bad++; $display("FAIL wait_wr_ctl got %b want 1000", {bus.iocs, bus.iorw, bus.ioaddr}); end
        n_cmp++; if (databus !== 8'h3C) begin n_bad++; $display("FAIL wait_wr_data got %h want 3c", databus); end
        cyc();
        n_cmp++; if (echo_cnt !== 8'h02) begin n_bad++; $display("FAIL wait_echo_cnt got %h want 02", echo_cnt); end
        n_cmp++; if (bus.iocs !== 1'b0) begin n_bad++; $display("FAIL heldoff_gap got %h want 0", bus.iocs); end
        cyc();
        n_cmp++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1100) begin n_bad++; $display("FAIL heldoff_rd_ctl got %b want 1100", {bus.iocs, bus.iorw, bus.ioaddr}); end
        bus.rda = 1'b0;
        cyc();
        n_cmp++; if (last_byte !== 8'hC3) begin n_bad++; $display("FAIL heldoff_last_byte got %h want c3", last_byte); end
        cyc();
        n_cmp++; if (databus !== 8'hC3) begin n_bad++; $display("FAIL heldoff_wr_data got %h want c3", databus); end
        cyc();
        n_cmp++; if (echo_cnt !== 8'h03) begin n_bad++; $display("FAIL heldoff_echo_cnt got %h want 03", echo_cnt); end
    endtask

    task test_cfg_idle();
        bus.tbr = 1'b0; br_cfg = 2'b11;
        cyc();
        n_cmp++; if (bus.iocs !== 1'b0) begin n_bad++; $display("FAIL cfgchg_sync1 got %h want 0", bus.iocs); end
        cyc();
        n_cmp++; if (bus.iocs !== 1'b0) begin n_bad++; $display("FAIL cfgchg_sync2 got %h want 0", bus.iocs); end
        cyc();
        n_cmp++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1010) begin n_bad++; $display("FAIL cfgchg_lo_ctl got %b want 1010", {bus.iocs, bus.iorw, bus.ioaddr}); end
        n_cmp++; if (databus !== 8'h52) begin n_bad++; $display("FAIL cfgchg_lo_data got %h want 52", databus); end
        cyc();
        n_cmp++; if ({bus.iocs, bus.ioaddr} !== 3'b111) begin n_bad++; $display("FAIL cfgchg_hi_ctl got %b want 111", {bus.iocs, bus.ioaddr}); end
        n_cmp++; if (databus !== 8'h00) begin n_bad++; $display("FAIL cfgchg_hi_data got %h want 00", databus); end
        cyc();
        n_cmp++; if (bus.iocs !== 1'b0) begin n_bad++; $display("FAIL cfgchg_done got %h want 0", bus.iocs); end
    endtask

    task test_cfg_wait();
        rx_byte = 8'h5E; bus.rda = 1'b1;
        cyc();
        n_cmp++; if ({bus.iocs, bus.iorw} !== 2'b11) begin n_bad++; $display("FAIL cfgwait_rd_ctl got %b want 11", {bus.iocs, bus.iorw}); end
        bus.rda = 1'b0; br_cfg = 2'b00;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_cmp++; if (bus.iocs !== 1'b0) begin n_bad++; $display("FAIL cfgwait_hold_%0d got %h want 0", i, bus.iocs); end
        end
        bus.tbr = 1'b1;
        cyc();
        n_cmp++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1000) begin n_bad++; $display("FAIL cfgwait_wr_ctl got %b want 1000", {bus.iocs, bus.iorw, bus.ioaddr}); end
        n_cmp++; if (databus !== 8'h5E) begin n_bad++; $display("FAIL cfgwait_wr_data got %h want 5e", databus); end
        bus.tbr = 1'b0;
        cyc();
        n_cmp++; if (bus.iocs !== 1'b0) begin n_bad++; $display("FAIL cfgwait_gap got %h want 0", bus.iocs); end
        cyc();
        n_cmp++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1010) begin n_bad++; $display("FAIL cfgwait_lo_ctl got %b want 1010", {bus.iocs, bus.iorw, bus.ioaddr}); end
        n_cmp++; if (databus !== 8'h8C) begin n_bad++; $display("FAIL cfgwait_lo_data got %h want 8c", databus); end
        cyc();
        n_cmp++; if (databus !== 8'h02) begin n_bad++; $display("FAIL cfgwait_hi_data got %h want 02", databus); end
        cyc();
        n_cmp++; if (echo_cnt !== 8'h04) begin n_bad++; $display("FAIL cfgwait_echo_cnt got %h want 04", echo_cnt); end
    endtask

    task test_back_to_back();
        exp_cnt = 8'h04;
        bus.tbr = 1'b1;
        for (int b = 0; b < 256; b++) begin
            rx_byte = 8'(b); bus.rda = 1'b1;
            cyc();
            n_cmp++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1100) begin n_bad++; $display("FAIL b2b_rd_ctl_%0d got %b want 1100", b, {bus.iocs, bus.iorw, bus.ioaddr}); end
            bus.rda = 1'b0;
            cyc();
            n_cmp++; if (databus !== 8'hFF || bus.iocs !== 1'b0) begin n_bad++; $display("FAIL b2b_gap1_%0d got bus %h iocs %h want ff 0", b, databus, bus.iocs); end
            cyc();
            n_cmp++; if (databus !== 8'(b) || bus.iorw !== 1'b0) begin n_bad++; $display("FAIL b2b_wr_%0d got %h want %h", b, databus, 8'(b)); end
            cyc();
            exp_cnt = exp_cnt + 8'h01;
            n_cmp++; if (databus !== 8'hFF || bus.iocs !== 1'b0) begin n_bad++; $display("FAIL b2b_gap2_%0d got bus %h iocs %h want ff 0", b, databus, bus.iocs); end
            n_cmp++; if (echo_cnt !== exp_cnt) begin n_bad++; $display("FAIL b2b_cnt_%0d got %h want %h", b, echo_cnt, exp_cnt); end
        end
    endtask

    task test_reset_mid_write();
        rx_byte = 8'h77; bus.rda = 1'b1; bus.tbr = 1'b1;
        cyc();
        bus.rda = 1'b0;
        cyc();
        cyc();
        n_cmp++; if (databus !== 8'h77) begin n_bad++; $display("FAIL midrst_wr_data got %h want 77", databus); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.iocs !== 1'b0) begin n_bad++; $display("FAIL midrst_iocs got %h want 0", bus.iocs); end
        n_cmp++; if (databus !== 8'hFF) begin n_bad++; $display("FAIL midrst_bus got %h want ff", databus); end
        n_cmp++; if (echo_cnt !== 8'h00) begin n_bad++; $display("FAIL midrst_echo_cnt got %h want 00", echo_cnt); end
        cyc();
        rst = 1'b0;
        cyc();
        n_cmp++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1010) begin n_bad++; $display("FAIL midrst_lo_ctl got %b want 1010", {bus.iocs, bus.iorw, bus.ioaddr}); end
        n_cmp++; if (databus !== 8'h8C) begin n_bad++; $display("FAIL midrst_lo_data got %h want 8c", databus); end
        cyc();
        n_cmp++; if (databus !== 8'h02) begin n_bad++; $display("FAIL midrst_hi_data got %h want 02", databus); end
    endtask

    initial begin
        bus.rda = 1'b0;
        bus.tbr = 1'b0;
        test_reset();
        test_echo();
        test_tbr_wait();
        test_cfg_idle();
        test_cfg_wait();
        test_back_to_back();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
